// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
// Shared types and defaults for the parallel-in/serial-out serializer.
//   state_t        : serializer FSM states
//   DEFAULT_WIDTH  : default word width, matches the 4-bit downstream SIPO
// -----------------------------------------------------------------------------
package piso_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage : piso_pkg

// File: rtl/piso_serializer_if.sv
// -----------------------------------------------------------------------------
// piso_serializer_if
// Load handshake plus serial output bundle for piso_serializer.
//   din        : parallel word, valid while load_valid is high
//   load_valid : upstream offers a word
//   load_ready : serializer can take a word this cycle
//   b          : serial data bit toward the SIPO
//   b_valid    : b carries a frame bit
//   last       : b is the final (MSB) bit of the frame
//   done       : one-cycle pulse, SIPO now holds the last accepted word
// Modports:
//   master : upstream producer / consumer of the serial stream
//   slave  : the serializer itself
// -----------------------------------------------------------------------------
interface piso_serializer_if
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             b;
  logic             b_valid;
  logic             last;
  logic             done;

  modport master (
    output din,
    output load_valid,
    input  load_ready,
    input  b,
    input  b_valid,
    input  last,
    input  done
  );

  modport slave (
    input  din,
    input  load_valid,
    output load_ready,
    output b,
    output b_valid,
    output last,
    output done
  );

endinterface : piso_serializer_if

// File: rtl/piso_bit_counter.sv
// -----------------------------------------------------------------------------
// piso_bit_counter
// CW-bit frame bit counter with synchronous clear and count enable.
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   clear    : return to zero on the next edge (wins over en)
//   en       : advance by one on the next edge
//   terminal : count is at WIDTH-1 (final bit of the frame)
// -----------------------------------------------------------------------------
module piso_bit_counter #(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic terminal
);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign terminal = (count == CW'(WIDTH - 1));

endmodule : piso_bit_counter

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
// Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out
// LSB first, one bit per clock, into a downstream WIDTH-deep SIPO. A new
// word may be accepted on the final bit of a frame, so back-to-back frames
// run without a gap. done pulses in the cycle the SIPO first holds the word.
//   clk : rising-edge clock, shared with the SIPO
//   rst : asynchronous active-low reset
//   bus : piso_serializer_if.slave (din, load_valid, load_ready,
//         b, b_valid, last, done)
// -----------------------------------------------------------------------------
module piso_serializer
  import piso_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  piso_serializer_if.slave   bus
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic             armed;
  logic             done_q;
  logic             busy;
  logic             terminal;
  logic             accept;
  logic             cnt_clear;
  logic             cnt_en;

  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .en       (cnt_en),
    .terminal (terminal)
  );

  // All outputs come straight from flops (state, shreg, counter, armed,
  // done_q) with only gating, so they are glitch-free toward the SIPO.
  assign busy         = (state == SHIFT);
  assign bus.b        = busy & shreg[0];
  assign bus.b_valid  = busy;
  assign bus.last     = busy & terminal;
  assign bus.done     = done_q;

  // armed keeps load_ready low while reset is asserted and for the first
  // cycle after release, since state alone already reads IDLE in reset.
  assign bus.load_ready = armed & (~busy | terminal);
  assign accept         = bus.load_valid & bus.load_ready;

  // NOTE: every signal written here gets a default first; a path that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          shreg_next = bus.din;
          cnt_clear  = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        cnt_en     = 1'b1;
        shreg_next = shreg >> 1;
        if (terminal) begin
          // Clearing on both exits keeps count within 0..WIDTH-1 even for
          // non-power-of-two widths.
          cnt_clear = 1'b1;
          if (accept) begin
            shreg_next = bus.din;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the shift register is reset along with the control flops; it is a
  // single word, not a memory array, so the reset costs nothing and keeps b
  // defined straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      shreg  <= '0;
      armed  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      shreg  <= shreg_next;
      armed  <= 1'b1;
      // The SIPO takes the final bit on this edge, so its q holds the full
      // word during the following cycle.
      done_q <= busy & terminal;
    end
  end

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
// Drives a 4-bit and an 8-bit piso_serializer, each feeding a behavioural
// SIPO shift register (q <= {b, q[W-1:1]}), and checks the serial stream,
// handshake, framing flags and done pulse against hand-computed values.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(4)) bus4 ();
  piso_serializer_if #(.WIDTH(8)) bus8 ();

  piso_serializer #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  piso_serializer #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  // Downstream SIPOs: no reset, shift right so the first (LSB) bit lands in q[0].
  logic [3:0] sipo4;
  logic [7:0] sipo8;
  always @(posedge clk) sipo4 <= {bus4.b, sipo4[3:1]};
  always @(posedge clk) sipo8 <= {bus8.b, sipo8[7:1]};

  // Observation vector: {b, b_valid, last, load_ready, done}
  logic [4:0] obs4;
  logic [4:0] obs8;
  assign obs4 = {bus4.b, bus4.b_valid, bus4.last, bus4.load_ready, bus4.done};
  assign obs8 = {bus8.b, bus8.b_valid, bus8.last, bus8.load_ready, bus8.done};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst             = 1'b0;
    bus4.load_valid = 1'b1;
    bus4.din        = 4'hF;
    bus8.load_valid = 1'b0;
    bus8.din        = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs4 !== 5'b00000) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %b expected %b", i, obs4, 5'b00000);
      end
    end
    rst             = 1'b1;
    bus4.load_valid = 1'b0;
    step();
    checks++;
    if (obs4 !== 5'b00010) begin
      errors++;
      $display("FAIL reset_release4: got %b expected %b", obs4, 5'b00010);
    end
    checks++;
    if (obs8 !== 5'b00010) begin
      errors++;
      $display("FAIL reset_release8: got %b expected %b", obs8, 5'b00010);
    end
  endtask

  task automatic test_single();
    logic [3:0] word;
    logic [4:0] exp;
    word            = 4'b1011;
    bus4.din        = word;
    bus4.load_valid = 1'b1;
    step();
    // Change din right after the accept edge; the captured word must not move.
    bus4.load_valid = 1'b0;
    bus4.din        = 4'h0;
    for (int k = 0; k < 4; k++) begin
      exp = {word[k], 1'b1, (k == 3), (k == 3), 1'b0};
      checks++;
      if (obs4 !== exp) begin
        errors++;
        $display("FAIL single_bit[%0d]: got %b expected %b", k, obs4, exp);
      end
      step();
    end
    checks++;
    if (obs4 !== 5'b00011) begin
      errors++;
      $display("FAIL single_done: got %b expected %b", obs4, 5'b00011);
    end
    checks++;
    if (sipo4 !== word) begin
      errors++;
      $display("FAIL single_sipo: got %h expected %h", sipo4, word);
    end
    step();
    checks++;
    if (obs4 !== 5'b00010) begin
      errors++;
      $display("FAIL single_after: got %b expected %b", obs4, 5'b00010);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] stream;
    logic [4:0] exp;
    stream          = 8'h5A;  // frame A then frame 5, LSB first
    bus4.din        = 4'hA;
    bus4.load_valid = 1'b1;
    step();
    bus4.din = 4'h5;          // held with load_valid until accepted
    for (int i = 0; i < 8; i++) begin
      if (i == 4) bus4.load_valid = 1'b0;
      exp = {stream[i], 1'b1, (i % 4 == 3), (i % 4 == 3), (i == 4)};
      checks++;
      if (obs4 !== exp) begin
        errors++;
        $display("FAIL b2b_bit[%0d]: got %b expected %b", i, obs4, exp);
      end
      if (i == 4) begin
        checks++;
        if (sipo4 !== 4'hA) begin
          errors++;
          $display("FAIL b2b_sipo_first: got %h expected %h", sipo4, 4'hA);
        end
      end
      step();
    end
    checks++;
    if (obs4 !== 5'b00011) begin
      errors++;
      $display("FAIL b2b_done_second: got %b expected %b", obs4, 5'b00011);
    end
    checks++;
    if (sipo4 !== 4'h5) begin
      errors++;
      $display("FAIL b2b_sipo_second: got %h expected %h", sipo4, 4'h5);
    end
    step();
  endtask

  task automatic test_busy_ignore();
    logic [7:0] stream;
    logic [4:0] exp;
    stream          = 8'h3C;  // frame C then frame 3, LSB first
    bus4.din        = 4'hC;
    bus4.load_valid = 1'b1;
    step();
    bus4.load_valid = 1'b0;
    bus4.din        = 4'h0;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        bus4.din        = 4'h3;
        bus4.load_valid = 1'b1;
      end
      if (i == 4) bus4.load_valid = 1'b0;
      exp = {stream[i], 1'b1, (i % 4 == 3), (i % 4 == 3), (i == 4)};
      checks++;
      if (obs4 !== exp) begin
        errors++;
        $display("FAIL busy_bit[%0d]: got %b expected %b", i, obs4, exp);
      end
      if (i == 4) begin
        checks++;
        if (sipo4 !== 4'hC) begin
          errors++;
          $display("FAIL busy_sipo_first: got %h expected %h", sipo4, 4'hC);
        end
      end
      step();
    end
    checks++;
    if (obs4 !== 5'b00011) begin
      errors++;
      $display("FAIL busy_done_second: got %b expected %b", obs4, 5'b00011);
    end
    checks++;
    if (sipo4 !== 4'h3) begin
      errors++;
      $display("FAIL busy_sipo_second: got %h expected %h", sipo4, 4'h3);
    end
    step();
  endtask

  task automatic test_midframe_reset();
    logic [3:0] word;
    logic [4:0] exp;
    word            = 4'h9;
    bus4.din        = word;
    bus4.load_valid = 1'b1;
    step();
    bus4.load_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp = {word[k], 1'b1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs4 !== exp) begin
        errors++;
        $display("FAIL midrst_bit[%0d]: got %b expected %b", k, obs4, exp);
      end
      if (k < 2) step();
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs4 !== 5'b00000) begin
      errors++;
      $display("FAIL midrst_async: got %b expected %b", obs4, 5'b00000);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs4 !== 5'b00000) begin
        errors++;
        $display("FAIL midrst_hold[%0d]: got %b expected %b", i, obs4, 5'b00000);
      end
    end
    rst = 1'b1;
    step();
    checks++;
    if (obs4 !== 5'b00010) begin
      errors++;
      $display("FAIL midrst_release: got %b expected %b", obs4, 5'b00010);
    end
    word            = 4'h6;
    bus4.din        = word;
    bus4.load_valid = 1'b1;
    step();
    bus4.load_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp = {word[k], 1'b1, (k == 3), (k == 3), 1'b0};
      checks++;
      if (obs4 !== exp) begin
        errors++;
        $display("FAIL midrst_next_bit[%0d]: got %b expected %b", k, obs4, exp);
      end
      step();
    end
    checks++;
    if (obs4 !== 5'b00011) begin
      errors++;
      $display("FAIL midrst_done: got %b expected %b", obs4, 5'b00011);
    end
    checks++;
    if (sipo4 !== word) begin
      errors++;
      $display("FAIL midrst_sipo: got %h expected %h", sipo4, word);
    end
    step();
  endtask

  task automatic test_width8();
    logic [7:0] word;
    logic [4:0] exp;
    word     = 8'h81;
    checks++;
    if (bus8.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL w8_ready: got %b expected %b", bus8.load_ready, 1'b1);
    end
    bus8.din        = word;
    bus8.load_valid = 1'b1;
    step();
    bus8.load_valid = 1'b0;
    bus8.din        = 8'h00;
    for (int k = 0; k < 8; k++) begin
      exp = {word[k], 1'b1, (k == 7), (k == 7), 1'b0};
      checks++;
      if (obs8 !== exp) begin
        errors++;
        $display("FAIL w8_bit[%0d]: got %b expected %b", k, obs8, exp);
      end
      step();
    end
    checks++;
    if (obs8 !== 5'b00011) begin
      errors++;
      $display("FAIL w8_done: got %b expected %b", obs8, 5'b00011);
    end
    checks++;
    if (sipo8 !== word) begin
      errors++;
      $display("FAIL w8_sipo: got %h expected %h", sipo8, word);
    end
    step();
    checks++;
    if (obs8 !== 5'b00010) begin
      errors++;
      $display("FAIL w8_after: got %b expected %b", obs8, 5'b00010);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_ignore();
    test_midframe_reset();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_piso_serializer

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out stage that feeds the team's 4-bit SIPO shift register through its serial input b.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock, LSB first.
- After WIDTH shifts, the downstream SIPO's q[WIDTH-1:0] holds the word with its original bit order.
- Raises a one-cycle done pulse in the cycle the SIPO output first holds the complete word.

Parameters:
- WIDTH, 4: word width; must equal the downstream SIPO depth; legal range 2..32.
- CW, $clog2(WIDTH): bit-counter width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock shared with the downstream SIPO.
- rst  input  1  asynchronous, active-low reset; 0 resets all state immediately.
- din  input  WIDTH  parallel word; sampled only on a load handshake.
- load_valid  input  1  upstream has a word on din.
- load_ready  output  1  block can accept a word this cycle.
- b  output  1  serial data; drives the SIPO b input.
- b_valid  output  1  b carries a frame bit this cycle.
- last  output  1  the current b is the final (MSB) bit of the frame.
- done  output  1  one-cycle pulse: the SIPO q equals the last accepted word.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, shift reg=0, count=0; b=0, b_valid=0, last=0, done=0, load_ready=0 while rst is low.
- FSM states: IDLE, SHIFT.
- Accept: a load is accepted on a rising edge where load_valid && load_ready.
- IDLE:
  - load_ready=1, b=0, b_valid=0.
  - On accept: shreg<=din, count<=0, go to SHIFT.
- SHIFT:
  - b=shreg[0], b_valid=1, last=(count==WIDTH-1); all outputs are registered.
  - Each edge: shreg<=shreg>>1 (zero fill), count<=count+1.
  - load_ready=last, so a back-to-back load is allowed on the final bit.
- Latency: din[0] appears on b in the first cycle after the accept edge. Bit k is on b in cycle k+1 after accept, for k=0..WIDTH-1.
- Exit from SHIFT when last is high:
  - with accept: reload shreg<=din, count<=0, stay in SHIFT; there is no gap cycle.
  - without accept: go to IDLE, b returns to 0.
- done: registered and asserted in the cycle after last was high. At that point the SIPO has taken WIDTH edges of frame bits and q==word. done asserts whether or not a new frame has started.
- load_valid while busy (not last): ignored, load_ready=0. Upstream must hold din and load_valid until accepted.
- din changing after accept: no effect; the word is captured at the accept edge.
- Reset mid-frame: the frame is abandoned and no done is issued. The SIPO has no reset wired, so its contents are don't-care until the next done.
- count wraps only through the reload path; it never exceeds WIDTH-1.

Decomposition:
- Package piso_pkg:
  - state typedef: enum {IDLE, SHIFT}.
  - localparam DEFAULT_WIDTH=4.
- One optional sub-module, piso_bit_counter (CW-bit up-counter with clear and enable, terminal flag at WIDTH-1). Otherwise a single module.
- Top-level bench instantiates piso_serializer driving the existing SIPO (b->b, shared clk).

Test Plan:
- Reset: hold rst=0 for 3 cycles with load_valid=1, din=4'hF -> b=0, b_valid=0, done=0, load_ready=0. Release rst -> load_ready=1 on the next cycle.
- Single word: din=4'b1011 accepted at edge T:
  - b sequence over cycles T+1..T+4 = 1,1,0,1.
  - last high only in T+4.
  - done high in T+5 only, with SIPO q=4'b1011.
  - load_ready back to 1 in T+5.
- Back-to-back: load_valid held high, words 4'hA then 4'h5, second accepted on A's last cycle:
  - b stream = 0,1,0,1,1,0,1,0 with no gap.
  - done pulses with q=4'hA, then 4 cycles later with q=4'h5.
- Busy ignore: assert load_valid with din=4'h3 during bit 1 of a 4'hC frame -> load_ready=0, frame 4'hC completes intact, and 4'h3 is accepted on the last cycle.
- Mid-frame reset: drop rst after bit 2 of 4'h9 -> all outputs 0 immediately, no done. After release, 4'h6 serializes normally and done shows q=4'h6.
- WIDTH=8 rerun against an 8-bit SIPO: word 8'h81 -> b = 1,0,0,0,0,0,0,1, done after 8 bits with q=8'h81.
